// File: rtl/lock_status_blinker.sv
// Display stage for the digital lock: passes steady status codes to the LEDs and turns alert codes into blink patterns.
// Optional RGB dimming is enabled by defining RGB_PWM_EN.
module lock_status_blinker #(
  parameter int unsigned CLK_FREQ = 125_000_000,
  parameter int unsigned BLINK_HZ = 25,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned PWM_DUTY = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] led_code,
  input  logic [2:0] rgb_code,
  output logic [3:0] led,
  output logic [2:0] rgb,
  output logic       tick
);

  localparam int unsigned PERIOD = CLK_FREQ / BLINK_HZ;
  localparam int unsigned CNT_W  = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  typedef enum logic [1:0] {
    STEADY,
    BLINK_A,
    BLINK_B
  } phase_e;

  logic [3:0]       led_code_q;
  logic [2:0]       rgb_code_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  phase_e           led_st_q, led_st_d;
  phase_e           rgb_st_q, rgb_st_d;
  logic [3:0]       led_q, led_d;
  logic [2:0]       rgb_q, rgb_d;
  logic             led_chg, rgb_chg, tick_int;

  // A code change restarts the timebase so the first phase is always full length.
  always_comb begin
    led_chg  = (led_code != led_code_q);
    rgb_chg  = (rgb_code != rgb_code_q);
    tick_int = (cnt_q == CNT_LAST) && !(led_chg || rgb_chg);
    if (led_chg || rgb_chg || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tick = tick_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_code_q <= '0;
      rgb_code_q <= '0;
      cnt_q      <= '0;
      led_st_q   <= STEADY;
      rgb_st_q   <= STEADY;
      led_q      <= '0;
      rgb_q      <= '0;
    end else begin
      led_code_q <= led_code;
      rgb_code_q <= rgb_code;
      cnt_q      <= cnt_d;
      led_st_q   <= led_st_d;
      rgb_st_q   <= rgb_st_d;
      led_q      <= led_d;
      rgb_q      <= rgb_d;
    end
  end

  always_comb begin
    led_st_d = led_st_q;
    if (led_chg) begin
      led_st_d = ((led_code == 4'b0101) || (led_code == 4'b1111)) ? BLINK_A : STEADY;
    end else if (tick_int) begin
      case (led_st_q)
        BLINK_A: led_st_d = BLINK_B;
        BLINK_B: led_st_d = BLINK_A;
        default: led_st_d = led_st_q;
      endcase
    end

    rgb_st_d = rgb_st_q;
    if (rgb_chg) begin
      rgb_st_d = ((rgb_code == 3'b001) || (rgb_code == 3'b010)) ? BLINK_A : STEADY;
    end else if (tick_int) begin
      case (rgb_st_q)
        BLINK_A: rgb_st_d = BLINK_B;
        BLINK_B: rgb_st_d = BLINK_A;
        default: rgb_st_d = rgb_st_q;
      endcase
    end
  end

  // Outputs are decoded from the next state so they land one cycle after a change or tick.
  always_comb begin
    case (led_st_d)
      BLINK_A: led_d = (led_code == 4'b1111) ? 4'b1111 : 4'b1010;
      BLINK_B: led_d = (led_code == 4'b1111) ? 4'b0000 : 4'b0101;
      default: led_d = led_code;
    endcase

    case (rgb_st_d)
      BLINK_A: rgb_d = (rgb_code == 3'b001) ? 3'b001 : 3'b010;
      BLINK_B: rgb_d = (rgb_code == 3'b001) ? 3'b100 : 3'b000;
      default: rgb_d = rgb_code;
    endcase
  end

  assign led = led_q;

`ifdef RGB_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_on;

  assign pwm_cnt_d = pwm_cnt_q + 1'b1;
  assign pwm_on    = (32'(pwm_cnt_q) < PWM_DUTY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign rgb = pwm_on ? rgb_q : '0;
`else
  logic unused_pwm_cfg;
  assign unused_pwm_cfg = ^{PWM_BITS, PWM_DUTY};
  assign rgb = rgb_q;
`endif

endmodule

// File: tb/tb_lock_status_blinker.sv
// Directed bench for lock_status_blinker with P = 100/10 = 10 cycles per phase.
module tb_lock_status_blinker;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] led_code;
  logic [2:0] rgb_code;
  logic [3:0] led;
  logic [2:0] rgb;
  logic       tick;

  int checks = 0;
  int errors = 0;

  lock_status_blinker #(
    .CLK_FREQ(100),
    .BLINK_HZ(10),
    .PWM_BITS(4),
    .PWM_DUTY(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .led_code(led_code),
    .rgb_code(rgb_code),
    .led(led),
    .rgb(rgb),
    .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] le, input logic [2:0] re, input logic te);
    chk({tag, ".led"}, led, le);
    chk({tag, ".rgb"}, {1'b0, rgb}, {1'b0, re});
    chk({tag, ".tick"}, {3'b000, tick}, {3'b000, te});
  endtask

  // Phase index k counts edges since the last restart (k=1 is the first edge).
  function automatic bit ph_b(input int k);
    return (((k - 1) / 10) % 2) == 1;
  endfunction

  initial begin
    rst = 1'b1;
    led_code = 4'b0000;
    rgb_code = 3'b000;
    repeat (3) step();
    check_all("reset", 4'b0000, 3'b000, 1'b0);

`ifdef RGB_PWM_EN
    begin
      int on_cnt;
      on_cnt = 0;
      rst = 1'b0;
      led_code = 4'b0010;
      rgb_code = 3'b100;
      step();
      for (int k = 0; k < 32; k++) begin
        step();
        chk("pwm.led", led, 4'b0010);
        checks++;
        assert (rgb === 3'b100 || rgb === 3'b000) else begin
          errors++;
          $error("FAIL pwm.rgb_val got=%b exp=100|000", rgb);
        end
        if (rgb === 3'b100) on_cnt++;
      end
      chk("pwm.on_count", 4'(on_cnt), 4'd8);
    end
`else
    rst = 1'b0;
    led_code = 4'b0010;
    rgb_code = 3'b100;
    for (int k = 1; k <= 50; k++) begin
      step();
      check_all("steady", 4'b0010, 3'b100, (k % 10) == 0);
    end

    led_code = 4'b0101;
    for (int k = 1; k <= 100; k++) begin
      step();
      check_all("led_alert", ph_b(k) ? 4'b0101 : 4'b1010, 3'b100, (k % 10) == 0);
    end

    // LED sits in phase B; the RGB change restarts the timebase without touching it.
    rgb_code = 3'b001;
    for (int k = 1; k <= 7; k++) begin
      step();
      check_all("rgb_first", 4'b0101, 3'b001, 1'b0);
    end
    rgb_code = 3'b010;
    for (int j = 1; j <= 25; j++) begin
      step();
      check_all("rgb_retime", ph_b(j) ? 4'b1010 : 4'b0101, ph_b(j) ? 3'b000 : 3'b010, (j % 10) == 0);
    end

    led_code = 4'b1111;
    rgb_code = 3'b100;
    for (int m = 1; m <= 15; m++) begin
      step();
      check_all("pre_rst", ph_b(m) ? 4'b0000 : 4'b1111, 3'b100, (m % 10) == 0);
    end
    #3 rst = 1'b1;
    #1 check_all("async_rst", 4'b0000, 3'b000, 1'b0);
    step();
    step();
    rst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      check_all("post_rst", ph_b(n) ? 4'b0000 : 4'b1111, 3'b100, (n % 10) == 0);
    end

    led_code = 4'b0101;
    for (int p = 1; p <= 10; p++) begin
      step();
      check_all("pre_tick", ph_b(p) ? 4'b0101 : 4'b1010, 3'b100, (p % 10) == 0);
    end
    led_code = 4'b1111;
    #1 check_all("chg_on_tick", 4'b1010, 3'b100, 1'b0);
    for (int q = 1; q <= 21; q++) begin
      step();
      check_all("post_chg", ph_b(q) ? 4'b0000 : 4'b1111, 3'b100, (q % 10) == 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
